// File: rtl/step_sequencer_core.sv
// 8-step pattern sequencer: encoder-driven step editing plus a tempo-driven
// playhead that emits a one-cycle strobe and a fixed-length gate per enabled step.
module step_sequencer_core #(
    parameter int TICK_CYCLES = 3_000_000,
    parameter int GATE_CYCLES = 600_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rotary_position,
    input  logic       button_pressed,
    input  logic       run,
    output logic [7:0] pattern,
    output logic [2:0] cursor,
    output logic [2:0] play_step,
    output logic       step_strobe,
    output logic       gate
);

    // state       | meaning
    // ST_STOPPED  | playhead frozen, tick/gate counters idle at 0
    // ST_RUNNING  | tick counter advancing, playhead steps every TICK_CYCLES

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = (GATE_CYCLES > 0) ? $clog2(GATE_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    pattern_q, pattern_d;
    logic [2:0]    cursor_q;
    logic [2:0]    play_step_q, play_step_d;
    logic          strobe_q, strobe_d;
    logic          gate_q, gate_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [GW-1:0] gate_cnt_q, gate_cnt_d;
    logic          btn_q;
    logic          press;
    logic [2:0]    next_step;

    always_comb begin
        press     = button_pressed & ~btn_q;
        next_step = play_step_q + 3'd1;

        pattern_d = pattern_q;
        if (press) begin
            pattern_d[cursor_q] = ~pattern_q[cursor_q];
        end

        state_d     = state_q;
        tick_d      = tick_q;
        play_step_d = play_step_q;
        strobe_d    = 1'b0;
        gate_cnt_d  = gate_cnt_q;
        gate_d      = gate_q;

        if (gate_cnt_q != '0) begin
            gate_cnt_d = gate_cnt_q - GW'(1);
            gate_d     = (gate_cnt_q != GW'(1));
        end

        if (state_q == ST_STOPPED) begin
            if (run) begin
                state_d = ST_RUNNING;
                tick_d  = '0;
            end
        end else begin
            if (!run) begin
                state_d    = ST_STOPPED;
                tick_d     = '0;
                gate_cnt_d = '0;
                gate_d     = 1'b0;
            end else if (tick_q == TICK_LAST) begin
                tick_d      = '0;
                play_step_d = next_step;
                strobe_d    = 1'b1;
                // post-edit pattern so a press landing on this edge counts
                if (pattern_d[next_step]) begin
                    gate_cnt_d = GATE_LOAD;
                    gate_d     = 1'b1;
                end else begin
                    gate_cnt_d = '0;
                    gate_d     = 1'b0;
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_STOPPED;
            pattern_q   <= 8'h00;
            cursor_q    <= 3'd0;
            play_step_q <= 3'd0;
            strobe_q    <= 1'b0;
            gate_q      <= 1'b0;
            tick_q      <= '0;
            gate_cnt_q  <= '0;
            btn_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            cursor_q    <= rotary_position;
            play_step_q <= play_step_d;
            strobe_q    <= strobe_d;
            gate_q      <= gate_d;
            tick_q      <= tick_d;
            gate_cnt_q  <= gate_cnt_d;
            btn_q       <= button_pressed;
        end
    end

    assign pattern     = pattern_q;
    assign cursor      = cursor_q;
    assign play_step   = play_step_q;
    assign step_strobe = strobe_q;
    assign gate        = gate_q;

endmodule
